l0_skew_fifo: RTL and testbench

Row-parallel input buffer (L0) feeding the west edge of the PE array. Each cycle it accepts one `row*bw`-bit vector, one `bw` slice per array row, into per-row circular FIFOs. It drains those FIFOs with a one-cycle-per-row diagonal skew, so row `i` presents its activation/weight nibble on `in_w` exactly `i` cycles after row 0, matching the per-row instruction skew at the array's west edge. Operand width and psum width are unaffected; this block only buffers and staggers `bw`-bit operands.

---
 rtl/l0_skew_fifo_if.sv | 26 ++
 rtl/l0_skew_fifo.sv | 85 ++++++++
 tb/tb_l0_skew_fifo.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/l0_skew_fifo_if.sv
// Bus between the L0 skew buffer and its producer/consumer. Handshake: a push
// happens on an edge where wr=1 and o_ready=1 (wr while not ready is dropped);
// a row slice of out is fresh data exactly on cycles where its o_valid bit is 1.
interface l0_skew_fifo_if #(
  parameter int row = 8,
  parameter int bw  = 4
);
  logic              wr;
  logic              rd;
  logic [row*bw-1:0] in;
  logic [row*bw-1:0] out;
  logic [row-1:0]    o_valid;
  logic              o_full;
  logic              o_ready;
  logic              o_empty;

  modport master (
    output wr, rd, in,
    input  out, o_valid, o_full, o_ready, o_empty
  );

  modport slave (
    input  wr, rd, in,
    output out, o_valid, o_full, o_ready, o_empty
  );
endinterface

// File: rtl/l0_skew_fifo.sv
// Row-parallel L0 buffer: one circular FIFO per PE-array row, written together
// and drained with a one-cycle-per-row diagonal skew toward the array's west edge.
module l0_skew_fifo #(
  parameter int row   = 8,
  parameter int bw    = 4,
  parameter int depth = 16
) (
  input  logic           clk,
  input  logic           reset,
  l0_skew_fifo_if.slave  bus
);
  localparam int AW = $clog2(depth);
  localparam int CW = AW + 1;

  logic [row-1:0] w_rd_en;
  logic [row-1:0] w_pop;
  logic [row-1:0] w_row_full;
  logic [row-1:0] w_row_empty;
  logic           w_wr_ok;

  logic [AW-1:0]  r_wr_ptr [row];
  logic [AW-1:0]  r_rd_ptr [row];
  logic [CW-1:0]  r_count  [row];
  logic [bw-1:0]  r_mem    [row][depth];
  logic [bw-1:0]  r_out    [row];
  logic           r_valid  [row];

  assign w_rd_en[0] = bus.rd;

  // Read enable ripples one row per edge, giving the diagonal skew.
  generate
    if (row > 1) begin : g_sr
      logic [row-2:0] r_rd_sr;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) r_rd_sr <= '0;
        else       r_rd_sr <= w_rd_en[row-2:0];
      end
      assign w_rd_en[row-1:1] = r_rd_sr;
    end
  endgenerate

  assign bus.o_full  = |w_row_full;
  assign bus.o_empty = &w_row_empty;
  assign bus.o_ready = ~bus.o_full;
  assign w_wr_ok     = bus.wr & ~bus.o_full;

  genvar g;
  generate
    for (g = 0; g < row; g++) begin : g_row
      assign w_row_full[g]  = (r_count[g] == CW'(depth));
      assign w_row_empty[g] = (r_count[g] == '0);
      // Emptiness uses the pre-edge count, so a write cannot be popped the same edge.
      assign w_pop[g]       = w_rd_en[g] & ~w_row_empty[g];

      always_ff @(posedge clk) begin
        if (w_wr_ok) r_mem[g][r_wr_ptr[g]] <= bus.in[g*bw +: bw];
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_wr_ptr[g] <= '0;
          r_rd_ptr[g] <= '0;
          r_count[g]  <= '0;
          r_out[g]    <= '0;
          r_valid[g]  <= 1'b0;
        end else begin
          r_valid[g] <= w_pop[g];
          if (w_pop[g]) begin
            r_out[g]    <= r_mem[g][r_rd_ptr[g]];
            r_rd_ptr[g] <= r_rd_ptr[g] + AW'(1);
          end
          if (w_wr_ok) r_wr_ptr[g] <= r_wr_ptr[g] + AW'(1);
          case ({w_wr_ok, w_pop[g]})
            2'b10:   r_count[g] <= r_count[g] + CW'(1);
            2'b01:   r_count[g] <= r_count[g] - CW'(1);
            default: r_count[g] <= r_count[g];
          endcase
        end
      end

      assign bus.out[g*bw +: bw] = r_out[g];
      assign bus.o_valid[g]      = r_valid[g];
    end
  endgenerate
endmodule

// File: tb/tb_l0_skew_fifo.sv
// Randomized bench for l0_skew_fifo: per-row queue reference model feeds an
// expected-data scoreboard drained by a negedge monitor.
module tb_l0_skew_fifo;
  localparam int ROW   = 8;
  localparam int BW    = 4;
  localparam int DEPTH = 16;
  localparam int W     = ROW * BW;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  l0_skew_fifo_if #(.row(ROW), .bw(BW)) bus ();

  l0_skew_fifo #(.row(ROW), .bw(BW), .depth(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [BW-1:0] mdl_q [ROW][$];
  logic [BW-1:0] exp_q [ROW][$];
  logic [BW-1:0] last_val [ROW];
  bit            exp_valid [ROW];
  bit            rd_log [$];
  bit            mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_full();
    bit f = 1'b0;
    for (int i = 0; i < ROW; i++) if (mdl_q[i].size() == DEPTH) f = 1'b1;
    return f;
  endfunction

  function automatic bit model_empty();
    bit e = 1'b1;
    for (int i = 0; i < ROW; i++) if (mdl_q[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < ROW; i++) begin
      mdl_q[i].delete();
      exp_q[i].delete();
      last_val[i]  = '0;
      exp_valid[i] = 1'b0;
    end
    rd_log.delete();
  endfunction

  // One clock edge: rd issued k edges ago pops row k; pops see pre-edge contents.
  function automatic void model_edge(input bit w, input bit r, input logic [W-1:0] v);
    bit full = model_full();
    int n;
    logic [BW-1:0] val;
    rd_log.push_back(r);
    n = rd_log.size() - 1;
    for (int i = 0; i < ROW; i++) begin
      exp_valid[i] = 1'b0;
      if (n - i >= 0 && rd_log[n-i] && mdl_q[i].size() > 0) begin
        val          = mdl_q[i].pop_front();
        last_val[i]  = val;
        exp_valid[i] = 1'b1;
        exp_q[i].push_back(val);
      end
    end
    if (w && !full)
      for (int i = 0; i < ROW; i++) mdl_q[i].push_back(v[i*BW +: BW]);
  endfunction

  task automatic cycle(input bit w, input bit r, input logic [W-1:0] v);
    bus.wr = w;
    bus.rd = r;
    bus.in = v;
    @(posedge clk);
    model_edge(w, r, v);
    #1;
    bus.wr = 1'b0;
    bus.rd = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0, W'($urandom));
  endtask

  function automatic logic [W-1:0] splat(input logic [BW-1:0] x);
    logic [W-1:0] v;
    for (int i = 0; i < ROW; i++) v[i*BW +: BW] = x;
    return v;
  endfunction

  // Monitor: checks every output against the model, pops data on each o_valid.
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      for (int i = 0; i < ROW; i++) begin
        chk($sformatf("valid_r%0d", i), 32'(bus.o_valid[i]), 32'(exp_valid[i]));
        chk($sformatf("out_r%0d", i), 32'(bus.out[i*BW +: BW]), 32'(last_val[i]));
        if (bus.o_valid[i] === 1'b1) begin
          if (exp_q[i].size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL pop_r%0d actual=unexpected_pop expected=no_pop t=%0t", i, $time);
          end else begin
            chk($sformatf("pop_data_r%0d", i), 32'(bus.out[i*BW +: BW]), 32'(exp_q[i].pop_front()));
          end
        end
      end
      chk("o_full", 32'(bus.o_full), 32'(model_full()));
      chk("o_empty", 32'(bus.o_empty), 32'(model_empty()));
      chk("o_ready", 32'(bus.o_ready), 32'(!model_full()));
    end
  end

  task automatic check_cleared(input string tag);
    chk({tag, "_out"}, 32'(bus.out), 32'(0));
    chk({tag, "_valid"}, 32'(bus.o_valid), 32'(0));
    chk({tag, "_empty"}, 32'(bus.o_empty), 32'(1));
    chk({tag, "_full"}, 32'(bus.o_full), 32'(0));
    chk({tag, "_ready"}, 32'(bus.o_ready), 32'(1));
  endtask

  initial begin
    logic [W-1:0] v;
    bus.wr = 1'b0;
    bus.rd = 1'b0;
    bus.in = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    reset  = 1'b0;
    check_cleared("reset");
    mon_en = 1'b1;

    // rd on empty FIFOs: no valid anywhere, out stays 0
    idle(2);
    cycle(1'b0, 1'b1, '0);
    idle(9);

    // skew: row i carries i+1
    for (int i = 0; i < ROW; i++) v[i*BW +: BW] = BW'(i + 1);
    cycle(1'b1, 1'b0, v);
    idle(1);
    cycle(1'b0, 1'b1, '0);
    idle(10);

    // fill and overflow: 17th write dropped
    for (int k = 0; k < 17; k++) cycle(1'b1, 1'b0, splat(BW'(k)));
    for (int k = 0; k < 16; k++) cycle(1'b0, 1'b1, '0);
    idle(10);

    // wrap-around
    for (int p = 0; p < 5; p++) begin
      for (int k = 0; k < 10; k++) cycle(1'b1, 1'b0, W'($urandom));
      for (int k = 0; k < 10; k++) cycle(1'b0, 1'b1, '0);
      idle(8);
    end

    // simultaneous wr+rd on empty: write lands, no pop
    cycle(1'b1, 1'b1, W'($urandom));
    idle(8);
    // fill to full, then wr+rd: pop happens, write dropped
    for (int k = 0; k < 15; k++) cycle(1'b1, 1'b0, W'($urandom));
    cycle(1'b1, 1'b1, W'($urandom));
    idle(8);
    for (int k = 0; k < 20; k++) cycle(1'b0, 1'b1, '0);
    idle(8);

    // half-full with continuous wr+rd
    for (int k = 0; k < 8; k++) cycle(1'b1, 1'b0, W'($urandom));
    for (int k = 0; k < 20; k++) cycle(1'b1, 1'b1, W'($urandom));
    for (int k = 0; k < 30; k++) cycle(1'b0, 1'b1, '0);
    idle(8);

    // random traffic
    for (int k = 0; k < 300; k++)
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), W'($urandom));
    for (int k = 0; k < 24; k++) cycle(1'b0, 1'b1, '0);
    idle(8);

    // reset mid-stream, three edges after rd on a loaded FIFO
    for (int k = 0; k < 5; k++) cycle(1'b1, 1'b0, W'($urandom));
    cycle(1'b0, 1'b1, '0);
    idle(2);
    #1;
    reset = 1'b1;
    model_reset();
    #1;
    check_cleared("midreset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    reset = 1'b0;
    idle(10);
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, W'($urandom));
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, '0);
    idle(10);

    mon_en = 1'b0;
    for (int i = 0; i < ROW; i++)
      chk($sformatf("leftover_r%0d", i), 32'(exp_q[i].size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
